// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the clock edge monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    localparam int EXPECTED_HALF_25M = 25;
    localparam int TIMEOUT_DEFAULT   = 64;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, with registered rise/fall/edge strobes.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall,
    output logic o_edge
);

    logic r_s1;
    logic r_s2;
    logic r_hist;
    logic r_rise;
    logic r_fall;
    logic r_edge;

    // History resets low, so an input already high at reset release yields one rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_hist <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value,
            // which is what makes this a shift chain rather than a single wire.
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_hist <= r_s2;
            r_rise <= r_s2 & ~r_hist;
            r_fall <= ~r_s2 & r_hist;
            r_edge <= r_s2 ^ r_hist;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
    assign o_edge = r_edge;

endmodule

// File: rtl/clock_edge_monitor.sv
// Samples a slow clock into clk, emits edge strobes, measures half-periods and tracks lock/loss.
module clock_edge_monitor
    import clk_mon_pkg::*;
#(
    parameter int EXPECTED_HALF = EXPECTED_HALF_25M,
    parameter int TOLERANCE     = 2,
    parameter int LOCK_COUNT    = 4,
    parameter int TIMEOUT       = TIMEOUT_DEFAULT,
    parameter int W             = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_in,
    output logic         rise_stb,
    output logic         fall_stb,
    output logic [W-1:0] half_period,
    output logic         period_err,
    output logic         locked,
    output logic         clk_lost
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [W-1:0]  HALF_LO   = W'(EXPECTED_HALF - TOLERANCE);
    localparam logic [W-1:0]  HALF_HI   = W'(EXPECTED_HALF + TOLERANCE);
    localparam logic [W-1:0]  CNT_SAT   = W'(TIMEOUT);
    localparam logic [W-1:0]  CNT_LAST  = W'(TIMEOUT - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);

    if (TOLERANCE >= EXPECTED_HALF) begin : g_bad_tolerance
        $error("clock_edge_monitor: TOLERANCE must be below EXPECTED_HALF");
    end
    if (TIMEOUT <= EXPECTED_HALF + TOLERANCE) begin : g_bad_timeout
        $error("clock_edge_monitor: TIMEOUT must exceed EXPECTED_HALF+TOLERANCE");
    end
    if (LOCK_COUNT < 1) begin : g_bad_lock_count
        $error("clock_edge_monitor: LOCK_COUNT must be at least 1");
    end

    logic          w_rise;
    logic          w_fall;
    logic          w_edge;
    logic [W-1:0]  r_cnt;
    logic [GW-1:0] r_good;
    logic [W-1:0]  w_meas;
    logic          w_in_tol;
    logic          w_timeout;
    logic          w_measured;
    state_t        r_state;
    state_t        w_next_state;
    logic          w_err_nx;
    logic          w_locked_nx;
    logic          w_lost_nx;
    logic [W-1:0]  r_half;
    logic          r_err;
    logic          r_locked;
    logic          r_lost;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (clk_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall),
        .o_edge  (w_edge)
    );

    // The edge cycle itself counts toward the gap, hence the +1.
    assign w_meas     = r_cnt + W'(1);
    assign w_in_tol   = (w_meas >= HALF_LO) && (w_meas <= HALF_HI);
    assign w_timeout  = !w_edge && (r_cnt == CNT_LAST);
    assign w_measured = (r_state == TRACK) || (r_state == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_good <= '0;
        end else if (w_edge) begin
            r_cnt  <= '0;
            r_good <= (r_state == TRACK && w_in_tol) ? r_good + GW'(1) : '0;
        end else if (r_cnt != CNT_SAT) begin
            r_cnt  <= r_cnt + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= SEARCH;
        else        r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves the signal unassigned,
        // which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            SEARCH: begin
                if (w_edge)         w_next_state = TRACK;
                else if (w_timeout) w_next_state = LOST;
            end
            TRACK: begin
                if (w_edge && w_in_tol && r_good == GOOD_LAST) w_next_state = LOCKED;
                else if (w_timeout)                             w_next_state = LOST;
            end
            LOCKED: begin
                if (w_edge && !w_in_tol) w_next_state = TRACK;
                else if (w_timeout)      w_next_state = LOST;
            end
            LOST: begin
                if (w_edge) w_next_state = TRACK;
            end
            default: w_next_state = SEARCH;
        endcase
    end

    always_comb begin
        w_err_nx    = w_edge && w_measured && !w_in_tol;
        w_locked_nx = (w_next_state == LOCKED);
        w_lost_nx   = (w_next_state == LOST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half   <= '0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            if (w_edge && w_measured) r_half <= w_meas;
            r_err    <= w_err_nx;
            r_locked <= w_locked_nx;
            r_lost   <= w_lost_nx;
        end
    end

    assign rise_stb    = w_rise;
    assign fall_stb    = w_fall;
    assign half_period = r_half;
    assign period_err  = r_err;
    assign locked      = r_locked;
    assign clk_lost    = r_lost;

endmodule
